// File: rtl/register_bank_mp.sv
// Multi-port register bank with a per-register busy scoreboard and optional write-to-read bypass.
// Reads are combinational with zero latency. Writes and busy sets take effect at the rising edge.
// No backpressure: every port is serviced every cycle, and colliding writes resolve to the highest-numbered port.
module register_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_async_n,
    input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*IDX_W-1:0]  wr_idx,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     busy_set_en,
    input  logic [IDX_W-1:0]         busy_set_idx,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [DEPTH];
    logic [NUM_WR-1:0] wr_ok;
    logic              set_ok;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W+1)'(DEPTH);
    endfunction

    // Index 0 is not a legal target when it is hardwired to zero.
    function automatic logic target_ok(input logic [IDX_W-1:0] idx);
        return in_range(idx) && !(ZERO_REG != 0 && idx == '0);
    endfunction

    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wr_en[w] && target_ok(wr_idx[w*IDX_W +: IDX_W]);
        end
        set_ok = busy_set_en && target_ok(busy_set_idx);
    end

    // Ascending port scan so the highest-numbered matching port overrides lower ones.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_val[i] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && wr_idx[w*IDX_W +: IDX_W] == IDX_W'(i)) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= wr_val[i];
                end
                // A fresh producer issued this cycle outranks the writeback of the old one.
                if (set_ok && busy_set_idx == IDX_W'(i)) begin
                    busy[i] <= 1'b1;
                end else if (wr_hit[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Reset gates the bypass path too, so nothing leaks out while rst_async_n is low.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            automatic logic [IDX_W-1:0] ridx = rd_idx[p*IDX_W +: IDX_W];
            if (rst_async_n && in_range(ridx)) begin
                if (BYPASS != 0 && wr_hit[ridx]) begin
                    rd_data[p*DATA_W +: DATA_W] = wr_val[ridx];
                end else begin
                    rd_data[p*DATA_W +: DATA_W] = regs[ridx];
                end
                rd_busy[p] = busy[ridx] && !(BYPASS != 0 && wr_hit[ridx]);
            end
        end
    end

    assign busy_vec = busy;

endmodule
